conv_mac_stream: RTL

Streaming multiply-accumulate stage of the 2D convolution accelerator. It consumes (pixel, weight) term pairs over AXI-Stream, with `TLAST` closing each convolution window. For each window it produces one saturated, optionally ReLU-clipped OUTW-bit result on an AXI-Stream master. It sits directly upstream of the output FIFO and drives that FIFO's input interface.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/mac_sat.sv | 47 ++++
 rtl/conv_mac_stream.sv | 66 ++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default widths, the term
// packing and the saturating add that is also used by the bias stage.
package conv_pkg;

  localparam int INW_DEF  = 10;
  localparam int OUTW_DEF = 24;

  typedef struct packed {
    logic signed [INW_DEF-1:0] weight;
    logic signed [INW_DEF-1:0] pixel;
  } term_t;

  // Operands arrive sign-extended to 64 bits. The sum is formed one bit
  // wider and then clamped to the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] p,
                                                 input int unsigned        width);
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = {acc[63], acc} + {p[63], p};
    hi  = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (width - 1));
    if (sum > hi) return hi[63:0];
    if (sum < lo) return lo[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Stage 2 of the MAC stream: saturating window accumulator and the result
// register that drives the downstream AXI-Stream.
module mac_sat
  import conv_pkg::*;
#(
  parameter int INW  = INW_DEF,
  parameter int OUTW = OUTW_DEF,
  parameter bit RELU = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   v1,
  input  logic                   l1,
  input  logic signed [2*INW-1:0] p1,
  output logic [OUTW-1:0]        data,
  output logic                   valid
);

  logic signed [OUTW-1:0] acc;
  logic signed [63:0]     acc_ext;
  logic signed [63:0]     p_ext;
  logic signed [OUTW-1:0] s;

  assign acc_ext = {{(64-OUTW){acc[OUTW-1]}}, acc};
  assign p_ext   = {{(64-2*INW){p1[2*INW-1]}}, p1};
  assign s       = OUTW'(sat_add(acc_ext, p_ext, OUTW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      if (v1 && l1) begin
        data  <= (RELU && s[OUTW-1]) ? '0 : s;
        valid <= 1'b1;
        acc   <= '0;
      end else begin
        // en=1 implies any pending result was accepted this edge
        valid <= 1'b0;
        if (v1) acc <= s;
      end
    end
  end

endmodule

// File: rtl/conv_mac_stream.sv
// Streaming multiply-accumulate: one (pixel, weight) term per cycle in, one
// saturated result per TLAST-delimited window out.
module conv_mac_stream
  import conv_pkg::*;
#(
  parameter int INW  = INW_DEF,
  parameter int OUTW = OUTW_DEF,
  parameter bit RELU = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*INW-1:0]   IN_AXIS_TDATA,
  input  logic               IN_AXIS_TVALID,
  input  logic               IN_AXIS_TLAST,
  output logic               IN_AXIS_TREADY,
  output logic [OUTW-1:0]    OUT_AXIS_TDATA,
  output logic               OUT_AXIS_TVALID,
  input  logic               OUT_AXIS_TREADY
);

  logic                    en;
  logic                    hs;
  logic signed [INW-1:0]   w;
  logic signed [INW-1:0]   x;
  logic signed [2*INW-1:0] prod;
  logic signed [2*INW-1:0] p1;
  logic                    v1;
  logic                    l1;

  // Whole pipeline freezes only while a result is waiting on downstream.
  assign en             = !(OUT_AXIS_TVALID && !OUT_AXIS_TREADY);
  assign IN_AXIS_TREADY = en && reset;
  assign hs             = IN_AXIS_TVALID && IN_AXIS_TREADY;

  assign w    = IN_AXIS_TDATA[2*INW-1:INW];
  assign x    = IN_AXIS_TDATA[INW-1:0];
  assign prod = {{INW{w[INW-1]}}, w} * {{INW{x[INW-1]}}, x};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1 <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else if (en) begin
      p1 <= prod;
      v1 <= hs;
      l1 <= IN_AXIS_TLAST;
    end
  end

  mac_sat #(
    .INW  (INW),
    .OUTW (OUTW),
    .RELU (RELU)
  ) u_mac_sat (
    .clk   (clk),
    .rst_n (reset),
    .en    (en),
    .v1    (v1),
    .l1    (l1),
    .p1    (p1),
    .data  (OUT_AXIS_TDATA),
    .valid (OUT_AXIS_TVALID)
  );

endmodule
